vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between the VGA scanout path and a host pixel-write port.
- Sits between the vga timing generator (hpos/vpos/display_on/hsync/vsync) and the RGB/HVsync pins.
- Fetches low-resolution cells for scanout with absolute priority. Grants host writes in free slots via valid/ready.
- Includes a hardware clear engine that fills the framebuffer with one colour.

---
 rtl/vga_fb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanout fetch (absolute priority), host writes, hardware clear engine.
// Optional macro VGA_FB_STATS_EN adds the stall_cnt port (host stall cycles since last vsync rise).
module vga_fb_arbiter #(
  parameter  int unsigned FB_W     = 160,
  parameter  int unsigned FB_H     = 120,
  parameter  int unsigned SCALE_SH = 2,
  parameter  int unsigned AW       = 15,
  localparam int unsigned CW       = 3,
  localparam int unsigned PW       = 10,
  localparam int unsigned SW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] hpos,
  input  logic [PW-1:0] vpos,
  input  logic          display_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] rgb,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          display_on_out,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          clear_req,
  input  logic [CW-1:0] clear_color,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [CW-1:0] ram_wdata,
  input  logic [CW-1:0] ram_rdata
`ifdef VGA_FB_STATS_EN
  ,
  output logic [SW-1:0] stall_cnt
`endif
);

  localparam int unsigned    CELLS     = FB_W * FB_H;
  localparam logic [AW-1:0] CELLS_A   = AW'(CELLS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_addr, clr_addr_next;
  logic [CW-1:0] clr_color, clr_color_next;
  logic          scan_fetch;
  logic [AW-1:0] fetch_addr;
  logic          display_on_d1, fetch_d1, hsync_d1, vsync_d1;
  logic [CW-1:0] cell_hold;

  // One RAM read per cell edge; the low hpos bits select the fetch slot.
  assign scan_fetch = display_on && (hpos[SCALE_SH-1:0] == '0);
  assign fetch_addr = AW'(vpos >> SCALE_SH) * AW'(FB_W) + AW'(hpos >> SCALE_SH);
  assign busy       = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clr_addr  <= '0;
      clr_color <= '0;
    end else begin
      state     <= state_next;
      clr_addr  <= clr_addr_next;
      clr_color <= clr_color_next;
    end
  end

  // RAM port arbitration and next-state; scan owns the address in its slot.
  always_comb begin
    state_next     = state;
    clr_addr_next  = clr_addr;
    clr_color_next = clr_color;
    wr_ready       = 1'b0;
    ram_addr       = '0;
    ram_we         = 1'b0;
    ram_wdata      = '0;

    if (scan_fetch) begin
      ram_addr = fetch_addr;
    end

    case (state)
      IDLE: begin
        wr_ready = !scan_fetch && !rst;
        if (wr_valid && wr_ready) begin
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
          ram_we    = (wr_addr < CELLS_A);
        end
        if (clear_req) begin
          state_next     = CLEAR;
          clr_addr_next  = '0;
          clr_color_next = clear_color;
        end
      end
      CLEAR: begin
        if (!scan_fetch && !rst) begin
          ram_addr      = clr_addr;
          ram_wdata     = clr_color;
          ram_we        = 1'b1;
          clr_addr_next = clr_addr + AW'(1);
          if (clr_addr == LAST_ADDR) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Two-stage pixel pipeline: RAM read latency plus output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_on_d1  <= 1'b0;
      fetch_d1       <= 1'b0;
      hsync_d1       <= 1'b0;
      vsync_d1       <= 1'b0;
      cell_hold      <= '0;
      rgb            <= '0;
      hsync_out      <= 1'b0;
      vsync_out      <= 1'b0;
      display_on_out <= 1'b0;
    end else begin
      display_on_d1  <= display_on;
      fetch_d1       <= scan_fetch;
      hsync_d1       <= hsync_in;
      vsync_d1       <= vsync_in;
      hsync_out      <= hsync_d1;
      vsync_out      <= vsync_d1;
      display_on_out <= display_on_d1;
      if (fetch_d1) begin
        cell_hold <= ram_rdata;
      end
      if (!display_on_d1) begin
        rgb <= '0;
      end else if (fetch_d1) begin
        rgb <= ram_rdata;
      end else begin
        rgb <= cell_hold;
      end
    end
  end

`ifdef VGA_FB_STATS_EN
  logic vsync_rise;

  assign vsync_rise = vsync_in && !vsync_d1;

  // Saturating count of host stall cycles, restarted every frame.
  always_ff @(posedge clk) begin
    if (rst || vsync_rise) begin
      stall_cnt <= '0;
    end else if (wr_valid && !wr_ready && (stall_cnt != {SW{1'b1}})) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: behavioural framebuffer model plus directed and random traffic.
module tb_vga_fb_arbiter;

  localparam int AW       = 15;
  localparam int FB_W     = 160;
  localparam int FB_CELLS = 19200;

  logic          clk = 1'b0;
  logic          rst, display_on, hsync_in, vsync_in;
  logic [9:0]    hpos, vpos;
  logic [2:0]    rgb;
  logic          hsync_out, vsync_out, display_on_out;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          clear_req;
  logic [2:0]    clear_color;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [2:0]    ram_wdata, ram_rdata;
`ifdef VGA_FB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .display_on_out(display_on_out), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef VGA_FB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Single-port RAM with one cycle read latency.
  logic [2:0] mem [0:(1<<AW)-1];
  logic [2:0] rdata_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = rdata_q;

  int checks, failures;

  // Reference model state.
  logic [2:0] fb [0:FB_CELLS-1];
  logic       m_busy;
  int         m_clr_next;
  logic [2:0] m_clr_color;
  logic [2:0] m_last;
  logic [5:0] pipe [$];
`ifdef VGA_FB_STATS_EN
  logic [15:0] m_stall, e_stall;
  logic        m_vs_prev;
`endif

  logic       e_busy, e_ready, e_we, e_addr_care, e_out_valid;
  int         e_addr;
  logic [2:0] e_wdata, e_rgb;
  logic       e_hs, e_vs, e_de;

  // Drive one pixel clock of inputs and compute what the design must show for it.
  task automatic drive_cycle(input logic r, input logic de, input int hp, input int vp,
                             input logic hs, input logic vs, input logic wv, input int wa,
                             input logic [2:0] wd, input logic cr, input logic [2:0] cc);
    logic       sf;
    int         fa;
    logic [2:0] pix;
    logic [5:0] ent;
    @(negedge clk);
    rst = r; display_on = de; hpos = 10'(hp); vpos = 10'(vp);
    hsync_in = hs; vsync_in = vs; wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
    clear_req = cr; clear_color = cc;
    #1;
    sf = de && (hp % 4 == 0);
    fa = (vp / 4) * FB_W + hp / 4;
    e_busy = m_busy; e_ready = 1'b0; e_we = 1'b0; e_addr_care = 1'b0; e_addr = 0; e_wdata = 3'd0;
    if (sf) begin
      e_addr_care = 1'b1; e_addr = fa;
    end else if (!r && m_busy) begin
      e_we = 1'b1; e_addr_care = 1'b1; e_addr = m_clr_next; e_wdata = m_clr_color;
    end else if (!r) begin
      e_ready = 1'b1;
      if (wv) begin
        e_addr_care = 1'b1; e_addr = wa; e_we = (wa < FB_CELLS); e_wdata = wd;
      end
    end
    e_out_valid = (pipe.size() >= 2);
    if (e_out_valid) begin
      ent = pipe.pop_front();
      {e_rgb, e_hs, e_vs, e_de} = ent;
    end
    pix = 3'd0;
    if (sf) pix = fb[fa];
    else if (de) pix = m_last;
`ifdef VGA_FB_STATS_EN
    e_stall = m_stall;
    if (r || (vs && !m_vs_prev)) m_stall = 16'd0;
    else if (wv && !e_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    m_vs_prev = r ? 1'b0 : vs;
`endif
    if (e_we) fb[e_addr] = e_wdata;
    if (r) begin
      m_busy = 1'b0; m_last = 3'd0;
      pipe.delete(); pipe.push_back(6'd0); pipe.push_back(6'd0);
    end else begin
      if (sf) m_last = pix;
      pipe.push_back({pix, hs, vs, de});
      if (m_busy && !sf) begin
        m_clr_next++;
        if (m_clr_next == FB_CELLS) m_busy = 1'b0;
      end else if (!m_busy && cr) begin
        m_busy = 1'b1; m_clr_next = 0; m_clr_color = cc;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 3'd1, 1'b0, 3'd0);
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
      checks++; if (rgb !== 3'd0) begin failures++; $display("FAIL reset_rgb got=%b exp=000", rgb); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      checks++; if (hsync_out !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%b exp=0", hsync_out); end
      checks++; if (vsync_out !== 1'b0) begin failures++; $display("FAIL reset_vsync got=%b exp=0", vsync_out); end
      checks++; if (display_on_out !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", display_on_out); end
    end
  endtask

  task automatic test_clear();
    drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b1, 3'd7);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy_early got=%b exp=0", busy); end
    for (int i = 0; i < FB_CELLS; i++) begin
      drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b1, 1234, 3'd2, 1'b0, 3'd0);
      checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_wdata !== 3'd7) begin
        failures++;
        $display("FAIL clear_write i=%0d got busy=%b ready=%b we=%b addr=%0d data=%0d exp 1 0 1 %0d 7",
                 i, busy, wr_ready, ram_we, ram_addr, ram_wdata, i);
        break;
      end
    end
    drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
    checks++; if (busy !== 1'b0 || e_busy !== 1'b0) begin failures++; $display("FAIL clear_done got busy=%b exp=0", busy); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL clear_done_we got=%b exp=0", ram_we); end
  endtask

  task automatic test_scan_fetch();
    drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b1, 161, 3'b101, 1'b0, 3'd0);
    checks++;
    if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(161)) begin
      failures++; $display("FAIL preload got ready=%b we=%b addr=%0d exp 1 1 161", wr_ready, ram_we, ram_addr);
    end
    for (int k = 0; k < 7; k++) begin
      drive_cycle(1'b0, (k < 4), 4 + k, 4, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
      if (k == 0) begin
        checks++;
        if (ram_addr !== AW'(161) || ram_we !== 1'b0) begin
          failures++; $display("FAIL fetch_addr got addr=%0d we=%b exp 161 0", ram_addr, ram_we);
        end
      end
      if (k >= 2 && k <= 5) begin
        checks++; if (rgb !== 3'b101) begin failures++; $display("FAIL fetch_rgb k=%0d got=%b exp=101", k, rgb); end
      end
      if (k == 6) begin
        checks++; if (rgb !== 3'b000) begin failures++; $display("FAIL fetch_rgb_blank got=%b exp=000", rgb); end
      end
      if (e_out_valid) begin
        checks++; if (display_on_out !== e_de) begin failures++; $display("FAIL fetch_de k=%0d got=%b exp=%b", k, display_on_out, e_de); end
      end
    end
  endtask

  task automatic test_write_stall();
    drive_cycle(1'b0, 1'b1, 8, 4, 1'b0, 1'b0, 1'b1, 5, 3'b010, 1'b0, 3'd0);
    checks++;
    if (wr_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== AW'(162)) begin
      failures++; $display("FAIL stall_slot got ready=%b we=%b addr=%0d exp 0 0 162", wr_ready, ram_we, ram_addr);
    end
    drive_cycle(1'b0, 1'b1, 9, 4, 1'b0, 1'b0, 1'b1, 5, 3'b010, 1'b0, 3'd0);
    checks++;
    if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(5) || ram_wdata !== 3'b010) begin
      failures++;
      $display("FAIL free_slot got ready=%b we=%b addr=%0d data=%b exp 1 1 5 010", wr_ready, ram_we, ram_addr, ram_wdata);
    end
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 700, 4, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic test_drop();
    int addrs [2];
    addrs[0] = FB_CELLS; addrs[1] = 32767;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b1, addrs[k], 3'd3, 1'b0, 3'd0);
      checks++;
      if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin
        failures++; $display("FAIL drop addr=%0d got ready=%b we=%b exp 1 0", addrs[k], wr_ready, ram_we);
      end
    end
  endtask

  task automatic test_random_traffic();
    logic       pv, de, hs, vs;
    int         pa, vp;
    logic [2:0] pd;
    pv = 1'b0; pa = 0; pd = 3'd0;
    for (int ln = 0; ln < 6; ln++) begin
      vp = int'($urandom_range(479, 0));
      for (int hp = 0; hp < 800; hp++) begin
        if (!pv && $urandom_range(2, 0) == 0) begin
          pv = 1'b1; pa = int'($urandom_range(19299, 0)); pd = 3'($urandom);
        end
        de = (hp < 640); hs = (hp >= 656 && hp < 752); vs = (ln == 3);
        drive_cycle(1'b0, de, hp, vp, hs, vs, pv, pa, pd, 1'b0, 3'd0);
        checks++; if (wr_ready !== e_ready) begin failures++; $display("FAIL rnd_ready hp=%0d got=%b exp=%b", hp, wr_ready, e_ready); end
        checks++; if (ram_we !== e_we) begin failures++; $display("FAIL rnd_we hp=%0d got=%b exp=%b", hp, ram_we, e_we); end
        if (e_addr_care) begin
          checks++; if (ram_addr !== AW'(e_addr)) begin failures++; $display("FAIL rnd_addr hp=%0d got=%0d exp=%0d", hp, ram_addr, e_addr); end
        end
        if (e_we) begin
          checks++; if (ram_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wdata got=%b exp=%b", ram_wdata, e_wdata); end
        end
        if (e_out_valid) begin
          checks++;
          if ({rgb, hsync_out, vsync_out, display_on_out} !== {e_rgb, e_hs, e_vs, e_de}) begin
            failures++;
            $display("FAIL rnd_pixel ln=%0d hp=%0d got rgb=%b hs=%b vs=%b de=%b exp %b %b %b %b",
                     ln, hp, rgb, hsync_out, vsync_out, display_on_out, e_rgb, e_hs, e_vs, e_de);
          end
        end
        if (pv && e_ready) pv = 1'b0;
      end
    end
  endtask

  task automatic test_rst_mid_clear();
    int hp, guard;
    drive_cycle(1'b0, 1'b1, 0, 8, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b1, 3'd6);
    hp = 1; guard = 0;
    while (m_clr_next != 100 && guard < 1000) begin
      drive_cycle(1'b0, 1'b1, hp % 640, 8, 1'b0, 1'b0, 1'b1, 77, 3'd1, 1'b0, 3'd0);
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL stallclr_busy got=%b exp=%b", busy, e_busy); end
      checks++; if (ram_we !== e_we || wr_ready !== 1'b0) begin failures++; $display("FAIL stallclr_we hp=%0d got we=%b ready=%b exp %b 0", hp % 640, ram_we, wr_ready, e_we); end
      if (e_addr_care) begin
        checks++; if (ram_addr !== AW'(e_addr)) begin failures++; $display("FAIL stallclr_addr got=%0d exp=%0d", ram_addr, e_addr); end
      end
      hp++; guard++;
    end
    checks++; if (guard >= 1000) begin failures++; $display("FAIL stallclr_timeout clr_addr=%0d exp=100", m_clr_next); end
    drive_cycle(1'b1, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
    drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b1, 3'd4);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
      checks++;
      if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_wdata !== 3'd4) begin
        failures++;
        $display("FAIL restart i=%0d got busy=%b we=%b addr=%0d data=%b exp 1 1 %0d 100", i, busy, ram_we, ram_addr, ram_wdata, i);
      end
    end
    drive_cycle(1'b1, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
    drive_cycle(1'b0, 1'b0, 700, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 3'd0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL final_busy got=%b exp=0", busy); end
  endtask

`ifdef VGA_FB_STATS_EN
  task automatic test_stats();
    logic pv;
    int   pa;
    pv = 1'b0; pa = 0;
    for (int hp = 0; hp < 640; hp++) begin
      if (!pv) begin pv = 1'b1; pa = int'($urandom_range(19199, 0)); end
      drive_cycle(1'b0, 1'b1, hp, 0, 1'b0, (hp >= 300 && hp < 310), pv, pa, 3'd5, 1'b0, 3'd0);
      checks++; if (stall_cnt !== e_stall) begin failures++; $display("FAIL stall_cnt hp=%0d got=%0d exp=%0d", hp, stall_cnt, e_stall); end
      if (pv && e_ready) pv = 1'b0;
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; display_on = 1'b0; hpos = '0; vpos = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0; clear_color = '0;
    m_busy = 1'b0; m_clr_next = 0; m_clr_color = 3'd0; m_last = 3'd0;
`ifdef VGA_FB_STATS_EN
    m_stall = 16'd0; m_vs_prev = 1'b0; e_stall = 16'd0;
`endif
    for (int i = 0; i < FB_CELLS; i++) fb[i] = 3'd0;
    test_reset();
    test_clear();
    test_scan_fetch();
    test_write_stall();
    test_drop();
    test_random_traffic();
    test_rst_mid_clear();
`ifdef VGA_FB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
